ov7670_cfg_seq: RTL and testbench

Camera register-initialisation sequencer. Sits directly downstream of the registered-output configuration ROM:
- drives the ROM address;
- consumes each 16-bit entry {reg_addr[15:8], reg_val[7:0]};
- issues one write per entry to the SCCB master through a valid/ready request and a done pulse.

Special entries mark end-of-table and a settle delay. The block reports busy/done to top-level control.

---
 rtl/ov7670_cfg_pkg.sv | 23 ++
 rtl/ov7670_cfg_seq_down_counter.sv | 27 ++
 rtl/ov7670_cfg_seq.sv | 146 ++++++++++++++
 tb/tb_ov7670_cfg_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cfg_pkg.sv
// Shared types and marker constants for the OV7670 register-initialisation sequencer.
package ov7670_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ROM_WAIT  = 3'd1,
        DECODE    = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4,
        DELAY     = 3'd5,
        FINISH    = 3'd6
    } cfg_state_t;

    // ROM words reserved as control markers rather than register writes.
    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK = 16'hFFF0;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] reg_val;
    } cfg_entry_t;

endpackage

// File: rtl/ov7670_cfg_seq_down_counter.sv
// Loadable down-counter that parks at zero; used for the settle delay and the SCCB timeout.
module cfg_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ov7670_cfg_seq.sv
// Walks the camera configuration ROM and turns each entry into one SCCB register write,
// honouring end-of-table and settle-delay marker entries.
module ov7670_cfg_seq
    import ov7670_cfg_pkg::*;
#(
    parameter int ROM_DEPTH      = 256,
    parameter int DELAY_CYCLES   = 1_000_000,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int ADDR_BITS      = $clog2(ROM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [15:0]          rom_data,
    output logic                 sccb_valid,
    input  logic                 sccb_ready,
    output logic [7:0]           sccb_reg,
    output logic [7:0]           sccb_val,
    input  logic                 sccb_done,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_BITS:0]   entry_cnt,
    output logic [2:0]           state_dbg
);

    // SCCB request: sccb_valid rises with sccb_reg/sccb_val already set, all three hold
    // unchanged until the edge where sccb_ready is also high, and valid drops on that edge.

    localparam int DW = $clog2(DELAY_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [DW-1:0]        DLY_LOAD  = DW'(DELAY_CYCLES - 1);
    localparam logic [TW-1:0]        TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(ROM_DEPTH - 1);

    cfg_state_t state;
    cfg_entry_t entry;
    logic       dly_load, dly_en, dly_zero;
    logic       to_load, to_en, to_zero;
    logic       at_last;

    assign entry     = rom_data;
    assign at_last   = (rom_addr == LAST_ADDR);
    assign state_dbg = state;

    assign dly_load = (state == DECODE) && (rom_data == DELAY_MARK);
    assign dly_en   = (state == DELAY);
    assign to_load  = (state == ISSUE) && sccb_ready;
    assign to_en    = (state == WAIT_DONE);

    cfg_down_counter #(.WIDTH(DW)) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (DLY_LOAD),
        .en       (dly_en),
        .zero     (dly_zero)
    );

    cfg_down_counter #(.WIDTH(TW)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (to_load),
        .load_val (TO_LOAD),
        .en       (to_en),
        .zero     (to_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rom_addr   <= '0;
            sccb_valid <= 1'b0;
            sccb_reg   <= '0;
            sccb_val   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            entry_cnt  <= '0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        rom_addr  <= '0;
                        entry_cnt <= '0;
                        err       <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ROM_WAIT;
                    end
                end
                ROM_WAIT: state <= DECODE;
                DECODE: begin
                    if (rom_data == END_MARK) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else if (rom_data == DELAY_MARK) begin
                        state <= DELAY;
                    end else begin
                        sccb_reg   <= entry.reg_addr;
                        sccb_val   <= entry.reg_val;
                        sccb_valid <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sccb_ready) begin
                        sccb_valid <= 1'b0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // A completion arriving on the timeout cycle still counts as success.
                    if (sccb_done || to_zero) begin
                        if (sccb_done) entry_cnt <= entry_cnt + 1'b1;
                        else           err       <= 1'b1;
                        if (at_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= ROM_WAIT;
                        end
                    end
                end
                DELAY: begin
                    if (dly_zero) begin
                        if (at_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= ROM_WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Scoreboard bench for ov7670_cfg_seq with a registered ROM model and an SCCB responder.
module tb_ov7670_cfg_seq;
    import ov7670_cfg_pkg::*;

    localparam int AB = 2;

    logic          clk, rst_n, start;
    logic [AB-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          sccb_valid, sccb_ready, sccb_done;
    logic [7:0]    sccb_reg, sccb_val;
    logic          busy, done, err;
    logic [AB:0]   entry_cnt;
    logic [2:0]    state_dbg;

    logic [15:0] rom_mem [4];
    logic [15:0] exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_hs, cnt_wait, cnt_delay, cnt_stall;
    int stall_req = 0;
    int done_delay = 10;
    logic done_en = 1'b1;
    int stall_seen;
    int done_timer;

    logic       prev_valid, prev_hs;
    logic [7:0] prev_reg, prev_val;

    ov7670_cfg_seq #(
        .ROM_DEPTH      (4),
        .DELAY_CYCLES   (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sccb_valid (sccb_valid),
        .sccb_ready (sccb_ready),
        .sccb_reg   (sccb_reg),
        .sccb_val   (sccb_val),
        .sccb_done  (sccb_done),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .entry_cnt  (entry_cnt),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // registered ROM: data follows the address by one clock
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // SCCB master model, reset by the same rst_n as the DUT
    assign sccb_ready = (stall_seen >= stall_req);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sccb_done  <= 1'b0;
            done_timer <= 0;
            stall_seen <= 0;
        end else begin
            sccb_done <= 1'b0;
            if (sccb_valid && sccb_ready) begin
                done_timer <= done_delay;
                stall_seen <= 0;
            end else begin
                if (sccb_valid) stall_seen <= stall_seen + 1;
                if (done_timer != 0) begin
                    done_timer <= done_timer - 1;
                    if (done_timer == 1 && done_en) sccb_done <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (state_dbg == WAIT_DONE) cnt_wait++;
            if (state_dbg == DELAY) cnt_delay++;
            if (sccb_valid && !sccb_ready) cnt_stall++;
            if (sccb_valid && prev_valid && !prev_hs) begin
                check("reg_stable", sccb_reg, prev_reg);
                check("val_stable", sccb_val, prev_val);
            end
            if (sccb_valid && sccb_ready) begin
                n_hs++;
                if (exp_q.size() == 0) check("sb_extra_write", exp_q.size(), 1);
                else check("sb_write", {sccb_reg, sccb_val}, exp_q.pop_front());
            end
            prev_valid = sccb_valid;
            prev_hs    = sccb_valid && sccb_ready;
            prev_reg   = sccb_reg;
            prev_val   = sccb_val;
        end else begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end
    end

    // driver tasks
    task automatic load_rom(input logic [15:0] a, b, c, d);
        rom_mem[0] = a; rom_mem[1] = b; rom_mem[2] = c; rom_mem[3] = d;
    endtask

    // reference walk of the table: which writes a run must produce
    task automatic expect_run();
        for (int i = 0; i < 4; i++) begin
            if (rom_mem[i] == 16'hFFFF) break;
            if (rom_mem[i] != 16'hFFF0) exp_q.push_back(rom_mem[i]);
        end
    endtask

    task automatic clear_stats();
        n_hs = 0; cnt_wait = 0; cnt_delay = 0; cnt_stall = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        @(negedge clk);
        check({tag, "_valid_e0"}, sccb_valid, 0);
        check({tag, "_busy"}, busy, 1);
        @(negedge clk);
        check({tag, "_valid_e1"}, sccb_valid, 0);
        @(negedge clk);
        check({tag, "_valid_e2"}, sccb_valid, 1);
    endtask

    task automatic wait_finish(input string tag, input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, done, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        clear_stats();
        repeat (3) @(negedge clk);
        check("reset_outputs", {rom_addr, sccb_valid, sccb_reg, sccb_val, busy, done, err, entry_cnt}, 0);
        check("reset_state", state_dbg, IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_release", {busy, done, state_dbg}, {2'b00, IDLE});

        // two plain writes, immediate ready
        load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'h0000);
        expect_run();
        clear_stats();
        pulse_start();
        check_latency("t1");
        wait_finish("t1", 200);
        check("t1_busy", busy, 0);
        check("t1_entry_cnt", entry_cnt, 2);
        check("t1_rom_addr", rom_addr, 2);
        check("t1_err", err, 0);
        check("t1_writes", n_hs, 2);
        check("t1_sb_drained", exp_q.size(), 0);

        // ready held low for 5 cycles on every request
        stall_req = 5;
        expect_run();
        clear_stats();
        pulse_start();
        wait_finish("t2", 300);
        check("t2_stall_cycles", cnt_stall, 10);
        check("t2_writes", n_hs, 2);
        check("t2_entry_cnt", entry_cnt, 2);
        check("t2_sb_drained", exp_q.size(), 0);
        stall_req = 0;

        // settle delay entry
        load_rom(16'hFFF0, 16'h1204, 16'hFFFF, 16'h0000);
        expect_run();
        clear_stats();
        pulse_start();
        begin
            int n = 0;
            while (!sccb_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("t3_first_valid_edge", n, 13);
        end
        wait_finish("t3", 200);
        check("t3_delay_cycles", cnt_delay, 8);
        check("t3_entry_cnt", entry_cnt, 1);
        check("t3_sb_drained", exp_q.size(), 0);

        // no completion: timeout sets err, run still finishes
        load_rom(16'h3A04, 16'hFFFF, 16'h0000, 16'h0000);
        done_en = 1'b0;
        expect_run();
        clear_stats();
        pulse_start();
        wait_finish("t4", 200);
        check("t4_err", err, 1);
        check("t4_wait_cycles", cnt_wait, 16);
        check("t4_entry_cnt", entry_cnt, 0);
        check("t4_rom_addr", rom_addr, 1);
        done_en = 1'b1;
        expect_run();
        pulse_start();
        @(negedge clk);
        check("t4_err_cleared", err, 0);
        wait_finish("t4b", 200);
        check("t4b_entry_cnt", entry_cnt, 1);
        check("t4b_err", err, 0);
        check("t4_sb_drained", exp_q.size(), 0);

        // full table without END_MARK, plus a start ignored while busy
        load_rom(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        expect_run();
        clear_stats();
        pulse_start();
        begin
            int n = 0;
            while (n_hs < 1 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        pulse_start();
        wait_finish("t5", 400);
        check("t5_rom_addr", rom_addr, 3);
        check("t5_entry_cnt", entry_cnt, 4);
        check("t5_writes", n_hs, 4);
        check("t5_sb_drained", exp_q.size(), 0);

        // async reset while waiting on the second write's completion
        load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'h0000);
        expect_run();
        clear_stats();
        pulse_start();
        begin
            int n = 0;
            while (!(n_hs == 2 && state_dbg == WAIT_DONE) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("t6_reached_wait", state_dbg, WAIT_DONE);
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_reset_outputs",
              {rom_addr, sccb_valid, sccb_reg, sccb_val, busy, done, err, entry_cnt}, 0);
        check("t6_async_reset_state", state_dbg, IDLE);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        expect_run();
        clear_stats();
        pulse_start();
        check_latency("t6");
        wait_finish("t6", 200);
        check("t6_entry_cnt", entry_cnt, 2);
        check("t6_rom_addr", rom_addr, 2);
        check("t6_sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
